// File: rtl/dadda_mult_pipe.sv
// dadda_mult_pipe: 3-stage pipelined Dadda multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Per-beat signed/unsigned mode, valid/ready on both sides, one global stall.
// Optional accumulate mode is enabled by defining DADDA_MULT_ACC_EN.
module dadda_mult_pipe #(
    parameter int WIDTH     = 16,
    parameter int ACC_GUARD = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic                         in_signed,
`ifdef DADDA_MULT_ACC_EN
    input  logic                         in_acc_clr,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef DADDA_MULT_ACC_EN
    output logic [2*WIDTH+ACC_GUARD-1:0] out_data
`else
    output logic [2*WIDTH-1:0]           out_data
`endif
);

    localparam int PW     = 2 * WIDTH;
    localparam int ROWS   = WIDTH + 1;
    localparam int CW     = $clog2(PW);
    localparam int RW     = $clog2(ROWS);
    localparam int WI     = $clog2(WIDTH);
    localparam int NSTAGE = 12;

    if (WIDTH < 4 || WIDTH > 32 || ACC_GUARD < 1) begin : g_bad_params
        $error("dadda_mult_pipe: WIDTH must be 4..32 and ACC_GUARD >= 1");
    end

    function automatic logic [CW-1:0] ci(input int v);
        return CW'(v);
    endfunction

    function automatic logic [RW-1:0] ri(input int v);
        return RW'(v);
    endfunction

    function automatic logic [WI-1:0] wi(input int v);
        return WI'(v);
    endfunction

    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] half_adder(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Dadda target heights, largest first; stages beyond the natural sequence
    // repeat d=2 and are empty unless an earlier stage ran short of bits.
    function automatic int stage_d(input int t);
        int ds [10];
        int n;
        ds[0] = 2;
        for (int k = 1; k < 10; k++) ds[k] = (ds[k-1] * 3) / 2;
        n = 0;
        for (int k = 0; k < 10; k++) if (ds[k] < WIDTH) n++;
        return (t < n) ? ds[n-1-t] : 2;
    endfunction

    logic                 advance;
    logic                 v1, v2;
    logic                 s1_signed, s2_signed;
    logic [WIDTH-1:0]     pp_d [WIDTH];
    logic [WIDTH-1:0]     pp_q [WIDTH];
    logic [PW-1:0]        row0_d, row1_d, row0_q, row1_q;
    logic [PW-1:0]        prod;
`ifdef DADDA_MULT_ACC_EN
    logic                 s1_acc_clr, s2_acc_clr;
`endif

    // Global stall: the whole pipe freezes while a result waits at the output.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    // Partial products; Baugh-Wooley inverts terms where exactly one operand bit is a sign bit.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_d[wi(i)][wi(j)] = (in_a[wi(j)] & in_b[wi(i)])
                                   ^ (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
    end

    // Stage 1: register partial products and the beat's mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            s1_signed <= 1'b0;
            pp_q      <= '{default: '0};
`ifdef DADDA_MULT_ACC_EN
            s1_acc_clr <= 1'b0;
`endif
        end else if (advance) begin
            v1 <= in_valid;
            if (in_valid) begin
                pp_q      <= pp_d;
                s1_signed <= in_signed;
`ifdef DADDA_MULT_ACC_EN
                s1_acc_clr <= in_acc_clr;
`endif
            end
        end
    end

    // Dadda reduction of the bit matrix (plus Baugh-Wooley constants) down to two rows.
    always_comb begin : dadda_tree
        logic [ROWS-1:0] mat  [PW];
        logic [ROWS-1:0] nmat [PW];
        int              ht   [PW];
        int              nht  [PW];
        int              d, excess, nfa, nha, p;
        logic [1:0]      cs;
        mat    = '{default: '0};
        nmat   = '{default: '0};
        ht     = '{default: 0};
        nht    = '{default: 0};
        d      = 0;
        excess = 0;
        nfa    = 0;
        nha    = 0;
        p      = 0;
        cs     = '0;
        row0_d = '0;
        row1_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                mat[ci(i+j)][ri(ht[ci(i+j)])] = pp_q[wi(i)][wi(j)];
                ht[ci(i+j)] = ht[ci(i+j)] + 1;
            end
        end
        mat[ci(WIDTH)][ri(ht[ci(WIDTH)])] = s1_signed;
        ht[ci(WIDTH)] = ht[ci(WIDTH)] + 1;
        mat[ci(PW-1)][ri(ht[ci(PW-1)])] = s1_signed;
        ht[ci(PW-1)] = ht[ci(PW-1)] + 1;
        for (int t = 0; t < NSTAGE; t++) begin
            d    = stage_d(t);
            nmat = '{default: '0};
            nht  = '{default: 0};
            for (int c = 0; c < PW; c++) begin
                // nht[c] already holds the carries arriving from column c-1.
                excess = ht[ci(c)] + nht[ci(c)] - d;
                nfa    = 0;
                nha    = 0;
                p      = 0;
                if (excess > 0) begin
                    nfa = excess / 2;
                    if (3 * nfa > ht[ci(c)]) nfa = ht[ci(c)] / 3;
                    if ((excess - 2 * nfa > 0) && (ht[ci(c)] - 3 * nfa >= 2)) nha = 1;
                end
                for (int k = 0; k < ROWS; k++) begin
                    if (k < nfa) begin
                        cs = full_adder(mat[ci(c)][ri(p)], mat[ci(c)][ri(p+1)], mat[ci(c)][ri(p+2)]);
                        nmat[ci(c)][ri(nht[ci(c)])] = cs[0];
                        nht[ci(c)] = nht[ci(c)] + 1;
                        if (c + 1 < PW) begin
                            nmat[ci(c+1)][ri(nht[ci(c+1)])] = cs[1];
                            nht[ci(c+1)] = nht[ci(c+1)] + 1;
                        end
                        p = p + 3;
                    end
                end
                if (nha == 1) begin
                    cs = half_adder(mat[ci(c)][ri(p)], mat[ci(c)][ri(p+1)]);
                    nmat[ci(c)][ri(nht[ci(c)])] = cs[0];
                    nht[ci(c)] = nht[ci(c)] + 1;
                    if (c + 1 < PW) begin
                        nmat[ci(c+1)][ri(nht[ci(c+1)])] = cs[1];
                        nht[ci(c+1)] = nht[ci(c+1)] + 1;
                    end
                    p = p + 2;
                end
                for (int k = 0; k < ROWS; k++) begin
                    if (k >= p && k < ht[ci(c)]) begin
                        nmat[ci(c)][ri(nht[ci(c)])] = mat[ci(c)][ri(k)];
                        nht[ci(c)] = nht[ci(c)] + 1;
                    end
                end
            end
            mat = nmat;
            ht  = nht;
        end
        for (int c = 0; c < PW; c++) begin
            row0_d[ci(c)] = mat[ci(c)][0];
            row1_d[ci(c)] = mat[ci(c)][1];
        end
    end

    // Stage 2: register the two reduced rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2        <= 1'b0;
            s2_signed <= 1'b0;
            row0_q    <= '0;
            row1_q    <= '0;
`ifdef DADDA_MULT_ACC_EN
            s2_acc_clr <= 1'b0;
`endif
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                row0_q    <= row0_d;
                row1_q    <= row1_d;
                s2_signed <= s1_signed;
`ifdef DADDA_MULT_ACC_EN
                s2_acc_clr <= s1_acc_clr;
`endif
            end
        end
    end

    assign prod = row0_q + row1_q;

`ifdef DADDA_MULT_ACC_EN
    logic [PW+ACC_GUARD-1:0] prod_ext;

    // Widen the product by its beat's mode before accumulating.
    always_comb begin
        prod_ext = s2_signed ? {{ACC_GUARD{prod[PW-1]}}, prod} : {{ACC_GUARD{1'b0}}, prod};
    end

    // Stage 3: out_data is the accumulator; it moves only when a beat advances into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= v2;
            if (v2) out_data <= s2_acc_clr ? prod_ext : out_data + prod_ext;
        end
    end
`else
    // Stage 3: final carry-propagate sum; the carry out of the top bit is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= v2;
            if (v2) out_data <= prod;
        end
    end
`endif

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Bench for dadda_mult_pipe (WIDTH=16, default build): reference products from plain
// integer multiplication, an in-order queue of expected results and a stall monitor.
module tb_dadda_mult_pipe;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_data;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             n_sent  = 0;
    int             n_recv  = 0;
    int             n_ready_low = 0;
    logic [2*W-1:0] exp_q [$];
    logic           prev_hold = 1'b0;
    logic [2*W-1:0] prev_data = '0;
    bit             rnd_done;

    always #5 clk = ~clk;

    dadda_mult_pipe #(.WIDTH(W), .ACC_GUARD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint     x, y;
        logic [63:0] p;
        x = s ? longint'($signed(a)) : longint'({1'b0, a});
        y = s ? longint'($signed(b)) : longint'({1'b0, b});
        p = 64'(x * y);
        return p[2*W-1:0];
    endfunction

    // Offer one beat from posedge+1 until taken; the expected result joins the queue on accept.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] e);
        int g;
        bit took;
        g    = 0;
        took = 1'b0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!took && g < 200);
        if (!took) check("accept_timeout", 0, 1);
        else begin
            exp_q.push_back(e);
            n_sent++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic s);
        logic [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        send(a, b, s, ref_mul(a, b, s));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (n_recv < n_sent && g < 500) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain", n_recv, n_sent);
    endtask

    // Output monitor: in-order scoreboard, hold-during-stall and in_ready rule.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (!in_ready) n_ready_low++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", out_data, 64'hDEAD);
                else begin
                    check("product", out_data, exp_q.pop_front());
                    n_recv++;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen, base;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency: one unsigned beat, out_ready high.
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_signed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(32'hFFFE0001);
        n_sent++;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("latency", lat, 3);
        check("latency_data", out_data, 32'hFFFE0001);
        drain();

        // Signed corner products, back-to-back with alternating modes.
        send(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        send(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
        send(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        send(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        send(16'h8000, 16'h7FFF, 1'b0, 32'h3FFF8000);
        send(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        send(16'h8000, 16'h8000, 1'b0, 32'h40000000);
        send(16'h0000, 16'hFFFF, 1'b1, 32'h00000000);
        drain();

        // Stream of 20 beats with out_ready low for cycles 5..9.
        base = n_recv;
        n_ready_low = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) send_rand(1'($urandom_range(0, 1)));
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    out_ready = !(c >= 5 && c <= 9);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("stall_count", n_recv - base, 20);
        check("stall_seen", (n_ready_low > 0), 1);

        // Reset with three beats in flight and the output stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_rand(1'(k % 2));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        n_sent = n_recv;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_emerge", seen, 0);
        @(posedge clk);
        #1;

        // Exhaustive small operands: 0..63 unsigned, -32..31 signed.
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                send(W'(i), W'(j), 1'b0, ref_mul(W'(i), W'(j), 1'b0));
                send(W'(i - 32), W'(j - 32), 1'b1, ref_mul(W'(i - 32), W'(j - 32), 1'b1));
            end
        end
        drain();

        // Full-range random beats with random output back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 10000; k++) send_rand(1'($urandom_range(0, 1)));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
